ssd_scan_ctrl: RTL

- Time-multiplexes the lock's 28-bit, four-digit seven-segment word onto one shared cathode bus and four anodes.
- Schedules which digit owns the display on each refresh slot.
- Inserts an anti-ghosting guard interval between digits.
- Applies a per-digit 1 Hz blink mask, so entry-state digits can flash while the user sets the switches.

---
 rtl/ssd_scan_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller: multiplexes a latched 28-bit segment word
// onto shared active-low cathodes with a blanking guard per slot and a per-digit blink mask.
module ssd_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 16,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [27:0] seg_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  input  logic        blink_sync,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_idx,
  output logic        blink_on
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] GUARD      = SW'(GUARD_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("ssd_scan_ctrl: REFRESH_DIV must be >= 2");
  end
  if (GUARD_CYC < 0 || GUARD_CYC >= REFRESH_DIV) begin : g_bad_guard
    $error("ssd_scan_ctrl: GUARD_CYC must be in [0, REFRESH_DIV)");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink
    $error("ssd_scan_ctrl: BLINK_DIV must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [1:0]        digit_d;
  logic [3:0][6:0]   seg_lat_q, seg_lat_d;
  logic [3:0]        dp_lat_q, dp_lat_d;
  logic [3:0]        mask_lat_q, mask_lat_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_on_d;
  logic              load;
  logic [3:0]        an_d;
  logic [6:0]        seg_d;
  logic              dp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      digit_idx   <= '0;
      seg_lat_q   <= '0;
      dp_lat_q    <= '0;
      mask_lat_q  <= '0;
      blink_cnt_q <= '0;
      blink_on    <= 1'b1;
      an          <= 4'b1111;
      seg         <= 7'h7F;
      dp          <= 1'b1;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      digit_idx   <= digit_d;
      seg_lat_q   <= seg_lat_d;
      dp_lat_q    <= dp_lat_d;
      mask_lat_q  <= mask_lat_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on    <= blink_on_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
    end
  end

  // Dropping enable wins over a slot boundary; the state follows from the next slot count.
  always_comb begin
    slot_d      = slot_q;
    digit_d     = digit_idx;
    seg_lat_d   = seg_lat_q;
    dp_lat_d    = dp_lat_q;
    mask_lat_d  = mask_lat_q;
    load        = 1'b0;
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_on_d  = blink_on;

    if (state_q == IDLE) begin
      if (enable) begin
        slot_d  = '0;
        digit_d = '0;
        load    = 1'b1;
      end
    end else if (enable) begin
      if (slot_q == SLOT_LAST) begin
        slot_d  = '0;
        digit_d = digit_idx + 2'd1;
        load    = 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end

    if (load) begin
      seg_lat_d  = seg_in;
      dp_lat_d   = dp_in;
      mask_lat_d = blink_mask;
    end

    state_d = enable ? ((slot_d >= GUARD) ? DRIVE : BLANK) : IDLE;

    if (blink_sync) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on;
    end
  end

  // Outputs are computed from next-cycle values so they change on the same edge as the state.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_d == DRIVE) begin
      seg_d = ~seg_lat_d[digit_d];
      dp_d  = ~dp_lat_d[digit_d];
      if (!(mask_lat_d[digit_d] && !blink_on_d)) begin
        an_d = ~(4'b0001 << digit_d);
      end
    end
  end

endmodule
